// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: single-outstanding req/ack bus master with byte lanes and load formatting.
// Optional macro LSU_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYC cycles without bus_ack.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] BM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ld_f3_q;
    logic [1:0]          addr_lo_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                acc_c, illegal_c, misalign_c, bad_c;
    logic                start_c, ack_take_c, timeout_c, done_fault_c;
    logic [3:0]          be_c;
    logic [DATA_W-1:0]   wdata_c;

    // Access legality decode on the M-stage inputs
    always_comb begin
        acc_c      = MemReadM | MemWriteM;
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        if (MemReadM && MemWriteM)
            illegal_c = 1'b1;
        if (MemReadM && (Funct3M == 3'b011 || Funct3M == 3'b110 || Funct3M == 3'b111))
            illegal_c = 1'b1;
        if (MemWriteM && !(Funct3M == 3'b000 || Funct3M == 3'b001 || Funct3M == 3'b010))
            illegal_c = 1'b1;
        if (Funct3M[1:0] == 2'b01 && ALUResultM[0])
            misalign_c = 1'b1;
        if (Funct3M == 3'b010 && ALUResultM[1:0] != 2'b00)
            misalign_c = 1'b1;
        bad_c = acc_c & (illegal_c | misalign_c);
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = BM;
        case (Funct3M[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << ALUResultM[1:0]);
                wdata_c = {4{BM[7:0]}};
            end
            2'b01: begin
                be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{BM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = BM;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             to_fault_q;

    assign timeout_c    = (state_q == S_BUSY) && !bus_ack &&
                          (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign done_fault_c = to_fault_q;

    // BUSY-cycle watchdog; cleared on every new access
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q   <= '0;
            to_fault_q <= 1'b0;
        end else begin
            to_fault_q <= timeout_c;
            if (start_c)
                to_cnt_q <= '0;
            else if (state_q == S_BUSY && !bus_ack)
                to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^32'(TIMEOUT_CYC);
    assign timeout_c          = 1'b0;
    assign done_fault_c       = 1'b0;
`endif

    // Next-state and pipeline control
    always_comb begin
        state_d    = state_q;
        StallM     = 1'b0;
        FaultM     = 1'b0;
        start_c    = 1'b0;
        ack_take_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_c) begin
                    if (bad_c) begin
                        FaultM = 1'b1;
                    end else begin
                        StallM  = 1'b1;
                        start_c = 1'b1;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                StallM = 1'b1;
                if (bus_ack) begin
                    ack_take_c = 1'b1;
                    state_d    = S_DONE;
                end else if (timeout_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                FaultM  = done_fault_c;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, bus and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            ld_f3_q   <= '0;
            addr_lo_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_c) begin
                bus_req   <= 1'b1;
                bus_we    <= MemWriteM;
                bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus_be    <= be_c;
                bus_wdata <= wdata_c;
                ld_f3_q   <= Funct3M;
                addr_lo_q <= ALUResultM[1:0];
            end
            if (ack_take_c) begin
                bus_req <= 1'b0;
                rdata_q <= bus_rdata;
            end else if (timeout_c) begin
                bus_req <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Load formatting; stores and non-DONE cycles present zero
    always_comb begin
        logic [7:0]  byte_c;
        logic [15:0] half_c;
        ReadDataM = '0;
        case (addr_lo_q)
            2'd0:    byte_c = rdata_q[7:0];
            2'd1:    byte_c = rdata_q[15:8];
            2'd2:    byte_c = rdata_q[23:16];
            default: byte_c = rdata_q[31:24];
        endcase
        half_c = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        if (state_q == S_DONE && !bus_we) begin
            case (ld_f3_q[1:0])
                2'b00:   ReadDataM = {{24{byte_c[7] & ~ld_f3_q[2]}}, byte_c};
                2'b01:   ReadDataM = {{16{half_c[15] & ~ld_f3_q[2]}}, half_c};
                2'b10:   ReadDataM = rdata_q;
                default: ReadDataM = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage; the timeout scenario runs only with LSU_TIMEOUT_EN.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, BM;
    logic [31:0] ReadDataM;
    logic        StallM, FaultM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .BM(BM),
        .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; BM = d;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0; #1;
        n_checks++; if (bus_req !== 1'b0)  begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_checks++; if (bus_we !== 1'b0)   begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", bus_we); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_checks++; if (bus_be !== 4'h0)   begin n_fail++; $display("FAIL reset_bus_be: got %b want 0000", bus_be); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
        n_checks++; if ({ReadDataM, StallM, FaultM} !== 34'h0) begin n_fail++; $display("FAIL reset_outputs: got rd=%h st=%b f=%b want 0", ReadDataM, StallM, FaultM); end
        // a stray ack while idle must not start anything
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        step();
        n_checks++; if ({bus_req, StallM, FaultM} !== 3'b000 || ReadDataM !== 32'h0) begin n_fail++; $display("FAIL idle_ack_ignored: got req=%b st=%b f=%b rd=%h want all 0", bus_req, StallM, FaultM, ReadDataM); end
    endtask

    task automatic test_lw();
        bus_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        n_checks++; if (StallM !== 1'b1 || FaultM !== 1'b0) begin n_fail++; $display("FAIL lw_idle: got st=%b f=%b want st=1 f=0", StallM, FaultM); end
        step();
        n_checks++; if ({bus_req, bus_we} !== 2'b10) begin n_fail++; $display("FAIL lw_busy_req: got req=%b we=%b want 1/0", bus_req, bus_we); end
        n_checks++; if (bus_addr !== 32'h100 || bus_be !== 4'b1111) begin n_fail++; $display("FAIL lw_busy_fields: got addr=%h be=%b want 100/1111", bus_addr, bus_be); end
        bus_ack = 1'b1; #1;
        n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL lw_busy_stall: got %b want 1", StallM); end
        step();
        bus_ack = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n_checks++; if (ReadDataM !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_done_data: got %h want deadbeef", ReadDataM); end
        n_checks++; if ({StallM, FaultM, bus_req} !== 3'b000) begin n_fail++; $display("FAIL lw_done_ctrl: got st=%b f=%b req=%b want 0/0/0", StallM, FaultM, bus_req); end
        step();
        n_checks++; if (ReadDataM !== 32'h0 || StallM !== 1'b0) begin n_fail++; $display("FAIL lw_after: got rd=%h st=%b want 0/0", ReadDataM, StallM); end
    endtask

    task automatic test_lb_lbu();
        logic [31:0] exp_rd [2];
        logic [2:0]  f3s    [2];
        exp_rd[0] = 32'hFFFF_FF80; f3s[0] = 3'b000;
        exp_rd[1] = 32'h0000_0080; f3s[1] = 3'b100;
        bus_rdata = 32'h80FF_1234;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, f3s[i], 32'h103, 32'h0);
            step();
            n_checks++; if (bus_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr[%0d]: got %h want 100", i, bus_addr); end
            bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            n_checks++; if (ReadDataM !== exp_rd[i]) begin n_fail++; $display("FAIL lb_data[%0d]: got %h want %h", i, ReadDataM, exp_rd[i]); end
            step();
        end
    endtask

    task automatic test_sb_delayed();
        int stalls;
        drive(1'b0, 1'b1, 3'b000, 32'h102, 32'h0000_00A5);
        stalls = 0;
        for (int c = 0; c < 5; c++) begin
            if (StallM === 1'b1) stalls++;
            if (c >= 1) begin
                n_checks++; if ({bus_req, bus_we} !== 2'b11 || bus_be !== 4'b0100 || bus_wdata !== 32'hA5A5_A5A5 || bus_addr !== 32'h100) begin n_fail++; $display("FAIL sb_busy[%0d]: got req=%b we=%b be=%b wd=%h addr=%h want 1/1/0100/a5a5a5a5/100", c, bus_req, bus_we, bus_be, bus_wdata, bus_addr); end
            end
            if (c == 4) begin bus_ack = 1'b1; #1; end
            step();
        end
        bus_ack = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n_checks++; if (stalls != 5) begin n_fail++; $display("FAIL sb_stall_count: got %0d want 5", stalls); end
        n_checks++; if ({StallM, bus_req} !== 2'b00 || ReadDataM !== 32'h0) begin n_fail++; $display("FAIL sb_done: got st=%b req=%b rd=%h want 0/0/0", StallM, bus_req, ReadDataM); end
        step();
    endtask

    task automatic test_back_to_back();
        // LH upper half (sign), then LHU lower half issued right after DONE, then SH upper lane
        bus_rdata = 32'h8001_7FFF;
        drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
        step(); bus_ack = 1'b1; step(); bus_ack = 1'b0;
        n_checks++; if (ReadDataM !== 32'hFFFF_8001) begin n_fail++; $display("FAIL b2b_lh: got %h want ffff8001", ReadDataM); end
        step();
        drive(1'b1, 1'b0, 3'b101, 32'h100, 32'h0);
        n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", StallM); end
        step(); bus_ack = 1'b1; step(); bus_ack = 1'b0;
        n_checks++; if (ReadDataM !== 32'h0000_7FFF) begin n_fail++; $display("FAIL b2b_lhu: got %h want 00007fff", ReadDataM); end
        step();
        drive(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_BEEF);
        step();
        n_checks++; if (bus_be !== 4'b1100 || bus_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL b2b_sh: got be=%b wd=%h want 1100/beefbeef", bus_be, bus_wdata); end
        bus_ack = 1'b1; step(); bus_ack = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_faults();
        logic       rds [4];
        logic       wrs [4];
        logic [2:0] f3s [4];
        logic [31:0] adr [4];
        // misaligned LW, misaligned LH, load+store together, illegal store funct3
        rds[0] = 1'b1; wrs[0] = 1'b0; f3s[0] = 3'b010; adr[0] = 32'h102;
        rds[1] = 1'b1; wrs[1] = 1'b0; f3s[1] = 3'b101; adr[1] = 32'h101;
        rds[2] = 1'b1; wrs[2] = 1'b1; f3s[2] = 3'b010; adr[2] = 32'h100;
        rds[3] = 1'b0; wrs[3] = 1'b1; f3s[3] = 3'b100; adr[3] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            drive(rds[i], wrs[i], f3s[i], adr[i], 32'h55);
            n_checks++; if ({FaultM, StallM} !== 2'b10 || ReadDataM !== 32'h0) begin n_fail++; $display("FAIL fault_pulse[%0d]: got f=%b st=%b rd=%h want 1/0/0", i, FaultM, StallM, ReadDataM); end
            step();
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            n_checks++; if ({FaultM, bus_req} !== 2'b00) begin n_fail++; $display("FAIL fault_after[%0d]: got f=%b req=%b want 0/0", i, FaultM, bus_req); end
        end
    endtask

    task automatic test_reset_busy();
        bus_rdata = 32'h1234_5678;
        drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        step();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rbusy_entry: got %b want 1", bus_req); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        bus_ack = 1'b1; #1;
        n_checks++; if ({bus_req, StallM} !== 2'b00) begin n_fail++; $display("FAIL rbusy_abort: got req=%b st=%b want 0/0", bus_req, StallM); end
        step();
        bus_ack = 1'b0; #1;
        n_checks++; if ({bus_req, StallM, FaultM} !== 3'b000 || ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rbusy_late_ack: got req=%b st=%b f=%b rd=%h want 0/0/0/0", bus_req, StallM, FaultM, ReadDataM); end
        step();
        n_checks++; if (ReadDataM !== 32'h0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL rbusy_no_done: got rd=%h req=%b want 0/0", ReadDataM, bus_req); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int busy;
        bus_rdata = 32'hCAFE_F00D;
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        step();
        busy = 0;
        while (bus_req === 1'b1 && StallM === 1'b1 && busy < 40) begin
            busy++;
            step();
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n_checks++; if (busy != 4) begin n_fail++; $display("FAIL timeout_busy_cycles: got %0d want 4", busy); end
        n_checks++; if ({FaultM, StallM, bus_req} !== 3'b100 || ReadDataM !== 32'h0) begin n_fail++; $display("FAIL timeout_done: got f=%b st=%b req=%b rd=%h want 1/0/0/0", FaultM, StallM, bus_req, ReadDataM); end
        step();
        n_checks++; if (FaultM !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_end: got %b want 0", FaultM); end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sb_delayed();
        test_back_to_back();
        test_faults();
        test_reset_busy();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
